mem_port_arbiter: RTL

- Shares one memory-controller burst port (read and write channels) between NUM_REQ requesters: rotation engine, video input writers and the display reader.
- Each requester sees the same valid/ready/burst_len/addr/data/burst_finish handshake it would see on a dedicated port.
- Only one burst, read or write, is in flight at a time.
- Requesters are served in round-robin order, and a watchdog flags a stuck burst.

---
 rtl/mem_port_arbiter.sv | 241 ++++++++++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory-controller burst port (read + write) among NUM_REQ requesters.
// Only one burst is open at a time; a watchdog closes a burst that never receives its finish.
//
// state    | meaning
// IDLE     | no burst open; pick the first requesting slot at/after the RR pointer
// GRANT    | grant_id valid; latch direction, address and length of that slot
// RD_BURST | rd_valid held with latched addr/len until rd_burst_finish or watchdog
// WR_BURST | wr_valid held with latched addr/len until wr_burst_finish or watchdog
// DONE     | dead cycle so the requester's valid can fall; advance RR pointer

module mem_port_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int MEM_DATA_LEN = 64,
    parameter int ADDR_LEN     = 32,
    parameter int TIMEOUT      = 4096
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_REQ-1:0]              req_rd_valid,
    input  logic [10*NUM_REQ-1:0]           req_rd_burst_len,
    input  logic [ADDR_LEN*NUM_REQ-1:0]     req_rd_addr,
    output logic [NUM_REQ-1:0]              req_rd_ready,
    output logic [MEM_DATA_LEN-1:0]         req_rd_data,
    output logic [NUM_REQ-1:0]              req_rd_burst_finish,
    input  logic [NUM_REQ-1:0]              req_wr_valid,
    input  logic [10*NUM_REQ-1:0]           req_wr_burst_len,
    input  logic [ADDR_LEN*NUM_REQ-1:0]     req_wr_addr,
    input  logic [MEM_DATA_LEN*NUM_REQ-1:0] req_wr_data,
    output logic [NUM_REQ-1:0]              req_wr_ready,
    output logic [NUM_REQ-1:0]              req_wr_burst_finish,
    output logic                            rd_valid,
    output logic [9:0]                      rd_burst_len,
    output logic [ADDR_LEN-1:0]             rd_addr,
    input  logic                            rd_ready,
    input  logic [MEM_DATA_LEN-1:0]         rd_data,
    input  logic                            rd_burst_finish,
    output logic                            wr_valid,
    output logic [9:0]                      wr_burst_len,
    output logic [ADDR_LEN-1:0]             wr_addr,
    output logic [MEM_DATA_LEN-1:0]         wr_data,
    input  logic                            wr_ready,
    input  logic                            wr_burst_finish,
    output logic [2:0]                      grant_id,
    output logic                            busy,
    output logic                            error
);

    localparam int             WW      = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [WW-1:0]  WD_LOAD = WW'(TIMEOUT - 1);
    localparam logic [2:0]     LAST    = 3'(NUM_REQ - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        GRANT    = 3'd1,
        RD_BURST = 3'd2,
        WR_BURST = 3'd3,
        DONE     = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic [2:0]            ptr_q, ptr_d;
    logic [2:0]            grant_id_q, grant_id_d;
    logic                  rd_valid_q, rd_valid_d;
    logic [9:0]            rd_len_q, rd_len_d;
    logic [ADDR_LEN-1:0]   rd_addr_q, rd_addr_d;
    logic                  wr_valid_q, wr_valid_d;
    logic [9:0]            wr_len_q, wr_len_d;
    logic [ADDR_LEN-1:0]   wr_addr_q, wr_addr_d;
    logic [WW-1:0]         wd_q, wd_d;
    logic                  error_q, error_d;

    logic [NUM_REQ-1:0]    any_req;
    logic [2:0]            pick;
    logic                  found;
    logic                  sel_rd_v, sel_wr_v;
    logic [9:0]            sel_rd_len, sel_wr_len;
    logic [ADDR_LEN-1:0]   sel_rd_addr, sel_wr_addr;
    logic [MEM_DATA_LEN-1:0] sel_wr_data;
    logic                  wd_tc;

    assign any_req = req_rd_valid | req_wr_valid;
    assign wd_tc   = (wd_q == '0);

    // First requesting slot scanning upward from the pointer, wrapping modulo NUM_REQ.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        for (int j = 0; j < NUM_REQ; j++) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (!found && any_req[k] && (k == (int'(ptr_q) + j) % NUM_REQ)) begin
                    found = 1'b1;
                    pick  = 3'(k);
                end
            end
        end
    end

    always_comb begin
        sel_rd_v    = 1'b0;
        sel_wr_v    = 1'b0;
        sel_rd_len  = '0;
        sel_wr_len  = '0;
        sel_rd_addr = '0;
        sel_wr_addr = '0;
        sel_wr_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_id_q == 3'(i)) begin
                sel_rd_v    = req_rd_valid[i];
                sel_wr_v    = req_wr_valid[i];
                sel_rd_len  = req_rd_burst_len[i*10 +: 10];
                sel_wr_len  = req_wr_burst_len[i*10 +: 10];
                sel_rd_addr = req_rd_addr[i*ADDR_LEN +: ADDR_LEN];
                sel_wr_addr = req_wr_addr[i*ADDR_LEN +: ADDR_LEN];
                sel_wr_data = req_wr_data[i*MEM_DATA_LEN +: MEM_DATA_LEN];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            grant_id_q <= '0;
            rd_valid_q <= 1'b0;
            rd_len_q   <= '0;
            rd_addr_q  <= '0;
            wr_valid_q <= 1'b0;
            wr_len_q   <= '0;
            wr_addr_q  <= '0;
            wd_q       <= '0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            grant_id_q <= grant_id_d;
            rd_valid_q <= rd_valid_d;
            rd_len_q   <= rd_len_d;
            rd_addr_q  <= rd_addr_d;
            wr_valid_q <= wr_valid_d;
            wr_len_q   <= wr_len_d;
            wr_addr_q  <= wr_addr_d;
            wd_q       <= wd_d;
            error_q    <= error_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        grant_id_d = grant_id_q;
        rd_valid_d = rd_valid_q;
        rd_len_d   = rd_len_q;
        rd_addr_d  = rd_addr_q;
        wr_valid_d = wr_valid_q;
        wr_len_d   = wr_len_q;
        wr_addr_d  = wr_addr_q;
        wd_d       = wd_q;
        error_d    = error_q;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    grant_id_d = pick;
                    state_d    = GRANT;
                end
            end
            GRANT: begin
                wd_d = WD_LOAD;
                // Read before write within one requester keeps read-modify-write ordering.
                if (sel_rd_v) begin
                    rd_valid_d = 1'b1;
                    rd_len_d   = sel_rd_len;
                    rd_addr_d  = sel_rd_addr;
                    state_d    = RD_BURST;
                end else if (sel_wr_v) begin
                    wr_valid_d = 1'b1;
                    wr_len_d   = sel_wr_len;
                    wr_addr_d  = sel_wr_addr;
                    state_d    = WR_BURST;
                end else begin
                    state_d = DONE;
                end
            end
            RD_BURST: begin
                if (rd_burst_finish || wd_tc) begin
                    rd_valid_d = 1'b0;
                    error_d    = error_q | ~rd_burst_finish;
                    state_d    = DONE;
                end else begin
                    wd_d = wd_q - 1'b1;
                end
            end
            WR_BURST: begin
                if (wr_burst_finish || wd_tc) begin
                    wr_valid_d = 1'b0;
                    error_d    = error_q | ~wr_burst_finish;
                    state_d    = DONE;
                end else begin
                    wd_d = wd_q - 1'b1;
                end
            end
            DONE: begin
                ptr_d   = (grant_id_q == LAST) ? 3'd0 : grant_id_q + 3'd1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Watchdog expiry stands in for the missing memory finish toward the requester.
    always_comb begin
        req_rd_ready        = '0;
        req_rd_burst_finish = '0;
        req_wr_ready        = '0;
        req_wr_burst_finish = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_id_q == 3'(i)) begin
                if (state_q == RD_BURST) begin
                    req_rd_ready[i]        = rd_ready;
                    req_rd_burst_finish[i] = rd_burst_finish | wd_tc;
                end
                if (state_q == WR_BURST) begin
                    req_wr_ready[i]        = wr_ready;
                    req_wr_burst_finish[i] = wr_burst_finish | wd_tc;
                end
            end
        end
    end

    assign req_rd_data  = rd_data;
    assign rd_valid     = rd_valid_q;
    assign rd_burst_len = rd_len_q;
    assign rd_addr      = rd_addr_q;
    assign wr_valid     = wr_valid_q;
    assign wr_burst_len = wr_len_q;
    assign wr_addr      = wr_addr_q;
    assign wr_data      = sel_wr_data;
    assign grant_id     = grant_id_q;
    assign busy         = (state_q != IDLE);
    assign error        = error_q;

endmodule
